// File: rtl/mcoc_boot_fetch_pkg.sv
// Shared state encoding and helpers for the boot-ROM fetch unit.
package mcoc_boot_fetch_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // fadr[1] value that selects rom word [31:16] when HI_FIRST=1
  localparam logic HI_FIRST_UPPER_A1 = 1'b0;

  function automatic logic hw_upper(input logic hi_first, input logic a1);
    return hi_first ? (a1 == HI_FIRST_UPPER_A1) : (a1 != HI_FIRST_UPPER_A1);
  endfunction

  function automatic int lat_cw(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  function automatic logic [31:0] fmt_word(input logic [31:0] w, input logic cmdl,
                                           input logic upper);
    if (cmdl) return w;
    return upper ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
  endfunction

endpackage

// File: rtl/mcoc_boot_fetch_lbuf.sv
// One-word line buffer: tag/data/valid register with hit compare.
module mcoc_boot_fetch_lbuf #(
  parameter int RAW = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_inv,
  input  logic           i_load,
  input  logic [RAW-1:0] i_load_tag,
  input  logic [31:0]    i_load_dat,
  input  logic [RAW-1:0] i_lkp_tag,
  output logic           o_hit,
  output logic [31:0]    o_dat
);

  logic           r_vld;
  logic [RAW-1:0] r_tag;
  logic [31:0]    r_dat;

  // a fill landing on the same edge as an invalidate is kept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_tag <= '0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_tag <= i_load_tag;
      r_dat <= i_load_dat;
    end else if (i_inv) begin
      r_vld <= 1'b0;
    end
  end

  assign o_hit = r_vld && (r_tag == i_lkp_tag) && !i_inv;
  assign o_dat = r_dat;

endmodule

// File: rtl/mcoc_boot_fetch.sv
// Boot-ROM fetch unit with handshake, ROM latency and one-word line buffer.
// Optional out-of-range flag enabled by defining MCOC_BOOT_FETCH_RANGE_CHK_EN.
module mcoc_boot_fetch
  import mcoc_boot_fetch_pkg::*;
#(
  parameter int AW       = 16,
  parameter int RAW      = 7,
  parameter int ROM_LAT  = 0,
  parameter int HI_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_freq,
  input  logic           i_fcmdl,
  input  logic [AW-1:0]  i_fadr,
  input  logic           i_finv,
  output logic           o_fbusy,
  output logic           o_fvld,
  output logic [31:0]    o_fdat,
  output logic           o_ferr,
  output logic [RAW-1:0] o_rom_adr,
  input  logic [31:0]    i_rom_dat
);

  localparam int CW = lat_cw(ROM_LAT);
  localparam logic HI = (HI_FIRST != 0);

  logic [0:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_cmdl;
  logic           r_a1;
  logic [RAW-1:0] r_rom_adr;
  logic           r_fvld;
  logic           r_ferr;
  logic [31:0]    r_fdat;

  logic [RAW-1:0] w_widx;
  logic           w_oor;
  logic           w_accept;
  logic           w_hit;
  logic           w_miss;
  logic           w_fill_done;
  logic           w_lb_load;
  logic [RAW-1:0] w_lb_tag;
  logic [31:0]    w_lb_dat;
  logic           w_unused;

  assign w_widx   = i_fadr[RAW+1:2];
  assign w_unused = ^i_fadr;

`ifdef MCOC_BOOT_FETCH_RANGE_CHK_EN
  if (AW > RAW + 2) begin : g_rchk
    assign w_oor = |i_fadr[AW-1:RAW+2];
  end else begin : g_nochk
    assign w_oor = 1'b0;
  end
`else
  assign w_oor = 1'b0;
`endif

  assign w_accept    = i_freq && (r_state == ST_IDLE);
  assign w_miss      = w_accept && !w_oor && !w_hit;
  assign w_fill_done = (r_state == ST_WAIT) && (r_cnt == CW'(1));
  assign w_lb_load   = (w_miss && (ROM_LAT == 0)) || w_fill_done;
  assign w_lb_tag    = (r_state == ST_WAIT) ? r_rom_adr : w_widx;

  mcoc_boot_fetch_lbuf #(.RAW(RAW)) u_lbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inv      (i_finv),
    .i_load     (w_lb_load),
    .i_load_tag (w_lb_tag),
    .i_load_dat (i_rom_dat),
    .i_lkp_tag  (w_widx),
    .o_hit      (w_hit),
    .o_dat      (w_lb_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cmdl    <= 1'b0;
      r_a1      <= 1'b0;
      r_rom_adr <= '0;
      r_fvld    <= 1'b0;
      r_ferr    <= 1'b0;
      r_fdat    <= '0;
    end else begin
      r_fvld <= 1'b0;
      r_ferr <= 1'b0;
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_fill_done) begin
          r_state <= ST_IDLE;
          r_fvld  <= 1'b1;
          r_fdat  <= fmt_word(i_rom_dat, r_cmdl, hw_upper(HI, r_a1));
        end
      end else if (w_accept) begin
        if (w_oor) begin
          r_fvld <= 1'b1;
          r_ferr <= 1'b1;
          r_fdat <= '0;
        end else begin
          r_rom_adr <= w_widx;
          if (w_hit) begin
            r_fvld <= 1'b1;
            r_fdat <= fmt_word(w_lb_dat, i_fcmdl, hw_upper(HI, i_fadr[1]));
          end else if (ROM_LAT == 0) begin
            r_fvld <= 1'b1;
            r_fdat <= fmt_word(i_rom_dat, i_fcmdl, hw_upper(HI, i_fadr[1]));
          end else begin
            // address stays on rom_adr through WAIT so a pipelined ROM sees it stable
            r_state <= ST_WAIT;
            r_cnt   <= CW'(ROM_LAT);
            r_cmdl  <= i_fcmdl;
            r_a1    <= i_fadr[1];
          end
        end
      end
    end
  end

  assign o_fbusy   = (r_state == ST_WAIT);
  assign o_fvld    = r_fvld;
  assign o_fdat    = r_fdat;
  assign o_ferr    = r_ferr;
  assign o_rom_adr = (w_accept && !w_oor) ? w_widx : r_rom_adr;

endmodule

// File: tb/tb_mcoc_boot_fetch.sv
// Directed scoreboard bench: four fetch units (ROM_LAT 0..3, last one HI_FIRST=0).
module tb_mcoc_boot_fetch;

  typedef struct {
    int          inst;
    int          lat;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [4];
  logic        freq    [4];
  logic        fcmdl   [4];
  logic [15:0] fadr    [4];
  logic        finv    [4];
  logic        fbusy   [4];
  logic        fvld    [4];
  logic [31:0] fdat    [4];
  logic        ferr    [4];
  logic [6:0]  rom_adr [4];
  logic [31:0] rom_dat [4];
  logic [31:0] rom_mem [4][128];

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  sb [$];
  string cur = "reset";

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    mcoc_boot_fetch #(
      .AW(16), .RAW(7), .ROM_LAT(gi), .HI_FIRST((gi == 3) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .i_freq    (freq[gi]),
      .i_fcmdl   (fcmdl[gi]),
      .i_fadr    (fadr[gi]),
      .i_finv    (finv[gi]),
      .o_fbusy   (fbusy[gi]),
      .o_fvld    (fvld[gi]),
      .o_fdat    (fdat[gi]),
      .o_ferr    (ferr[gi]),
      .o_rom_adr (rom_adr[gi]),
      .i_rom_dat (rom_dat[gi])
    );
    if (gi == 0) begin : g_comb
      assign rom_dat[gi] = rom_mem[gi][rom_adr[gi]];
    end else begin : g_pipe
      // address pipeline models a ROM whose data appears gi cycles after the address
      logic [6:0] pipe [0:gi-1];
      always_ff @(posedge clk) begin
        pipe[0] <= rom_adr[gi];
        for (int k = 1; k < gi; k++) pipe[k] <= pipe[k-1];
      end
      assign rom_dat[gi] = rom_mem[gi][pipe[gi-1]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int i, input int lat, input logic [31:0] d, input logic e);
    exp_t x;
    x.inst = i; x.lat = lat; x.dat = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic issue(input int i, input logic cmdl, input logic [15:0] adr, input logic inv);
    freq[i] = 1'b1; fcmdl[i] = cmdl; fadr[i] = adr; finv[i] = inv;
  endtask

  task automatic release_req(input int i);
    step();
    freq[i] = 1'b0;
    finv[i] = 1'b0;
  endtask

  task automatic check_now(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s/sb: observed empty queue expected pending entry", cur);
      return;
    end
    e = sb.pop_front();
    chk({cur, "/fvld"}, 32'(fvld[e.inst]), 32'd1);
    chk({cur, "/lat"},  32'(k), 32'(e.lat));
    chk({cur, "/fdat"}, fdat[e.inst], e.dat);
    chk({cur, "/ferr"}, 32'(ferr[e.inst]), 32'(e.err));
    $display("[TB] %s inst%0d lat=%0d fdat=%h ferr=%0d", cur, e.inst, k, fdat[e.inst], ferr[e.inst]);
  endtask

  task automatic wait_rsp();
    int i;
    int k;
    i = sb[0].inst;
    k = 1;
    while (fvld[i] !== 1'b1 && k < 12) begin
      step();
      k++;
    end
    check_now(k);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; freq[i] = 1'b0; fcmdl[i] = 1'b0; fadr[i] = '0; finv[i] = 1'b0;
      for (int w = 0; w < 128; w++) rom_mem[i][w] = {16'hC0DE, 8'(i), 8'(w)};
      rom_mem[i][0] = 32'hAAAA_5555;
      rom_mem[i][3] = 32'h1234_5678;
      rom_mem[i][4] = 32'hCAFE_F00D;
    end
    step(); step(); step();
    for (int i = 0; i < 4; i++) begin
      chk("rst/fvld",    32'(fvld[i]), 32'd0);
      chk("rst/fbusy",   32'(fbusy[i]), 32'd0);
      chk("rst/fdat",    fdat[i], 32'd0);
      chk("rst/ferr",    32'(ferr[i]), 32'd0);
      chk("rst/rom_adr", 32'(rom_adr[i]), 32'd0);
    end
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    step();

    // ROM_LAT=0
    cur = "lat0_miss";
    issue(0, 1'b1, 16'h000C, 1'b0); push(0, 1, 32'h1234_5678, 1'b0);
    #1 chk({cur, "/rom_adr"}, 32'(rom_adr[0]), 32'd3);
    release_req(0); wait_rsp();
    cur = "lat0_hit_hw";
    issue(0, 1'b0, 16'h000E, 1'b0); push(0, 1, 32'h0000_5678, 1'b0);
    #1 chk({cur, "/rom_adr"}, 32'(rom_adr[0]), 32'd3);
    release_req(0); wait_rsp();
    cur = "lat0_b2b";
    issue(0, 1'b1, 16'h000C, 1'b0); push(0, 1, 32'h1234_5678, 1'b0);
    step(); check_now(1);
    issue(0, 1'b0, 16'h000C, 1'b0); push(0, 1, 32'h0000_1234, 1'b0);
    release_req(0); check_now(1);
    step(); chk({cur, "/single"}, 32'(fvld[0]), 32'd0);

    // ROM_LAT=2: busy window, dropped request, rehit
    cur = "lat2_miss";
    issue(2, 1'b1, 16'h0010, 1'b0); push(2, 3, 32'hCAFE_F00D, 1'b0);
    release_req(2);
    chk({cur, "/busy1"}, 32'(fbusy[2]), 32'd1);
    chk({cur, "/rom_adr1"}, 32'(rom_adr[2]), 32'd4);
    issue(2, 1'b1, 16'h000C, 1'b0);
    step(); freq[2] = 1'b0;
    chk({cur, "/busy2"}, 32'(fbusy[2]), 32'd1);
    chk({cur, "/early"}, 32'(fvld[2]), 32'd0);
    chk({cur, "/rom_adr2"}, 32'(rom_adr[2]), 32'd4);
    step(); check_now(3);
    chk({cur, "/busy3"}, 32'(fbusy[2]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(); chk({cur, "/dropped"}, 32'(fvld[2]), 32'd0);
    end
    cur = "lat2_rehit";
    issue(2, 1'b1, 16'h0010, 1'b0); push(2, 1, 32'hCAFE_F00D, 1'b0);
    release_req(2); wait_rsp();

    // ROM_LAT=1: invalidate with request, invalidate during WAIT
    cur = "lat1_fill";
    issue(1, 1'b1, 16'h0010, 1'b0); push(1, 2, 32'hCAFE_F00D, 1'b0);
    release_req(1); wait_rsp();
    cur = "lat1_hit";
    issue(1, 1'b1, 16'h0010, 1'b0); push(1, 1, 32'hCAFE_F00D, 1'b0);
    release_req(1); wait_rsp();
    rom_mem[1][4] = 32'h5EED_BEEF;
    cur = "lat1_inv";
    issue(1, 1'b1, 16'h0010, 1'b1); push(1, 2, 32'h5EED_BEEF, 1'b0);
    #1 chk({cur, "/rom_adr"}, 32'(rom_adr[1]), 32'd4);
    release_req(1);
    chk({cur, "/busy"}, 32'(fbusy[1]), 32'd1);
    wait_rsp();
    cur = "lat1_keep";
    issue(1, 1'b0, 16'h0012, 1'b0); push(1, 1, 32'h0000_BEEF, 1'b0);
    release_req(1); wait_rsp();
    cur = "lat1_inv_wait";
    issue(1, 1'b1, 16'h000C, 1'b0); push(1, 2, 32'h1234_5678, 1'b0);
    release_req(1); finv[1] = 1'b1;
    step(); finv[1] = 1'b0; check_now(2);
    cur = "lat1_inv_kept";
    issue(1, 1'b0, 16'h000C, 1'b0); push(1, 1, 32'h0000_1234, 1'b0);
    release_req(1); wait_rsp();

    // ROM_LAT=3, HI_FIRST=0: reset mid-miss
    cur = "lat3_fill";
    issue(3, 1'b1, 16'h000C, 1'b0); push(3, 4, 32'h1234_5678, 1'b0);
    release_req(3); wait_rsp();
    cur = "lat3_hit";
    issue(3, 1'b1, 16'h000C, 1'b0); push(3, 1, 32'h1234_5678, 1'b0);
    release_req(3); wait_rsp();
    cur = "lat3_rst";
    issue(3, 1'b1, 16'h0010, 1'b0);
    release_req(3);
    chk({cur, "/busy"}, 32'(fbusy[3]), 32'd1);
    rst_n[3] = 1'b0;
    step();
    chk({cur, "/fvld"}, 32'(fvld[3]), 32'd0);
    chk({cur, "/fbusy"}, 32'(fbusy[3]), 32'd0);
    chk({cur, "/fdat"}, fdat[3], 32'd0);
    rst_n[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(); chk({cur, "/nofvld"}, 32'(fvld[3]), 32'd0);
    end
    cur = "lat3_after_rst";
    issue(3, 1'b1, 16'h000C, 1'b0); push(3, 4, 32'h1234_5678, 1'b0);
    release_req(3); wait_rsp();
    cur = "hi0_lo";
    issue(3, 1'b0, 16'h0000, 1'b0); push(3, 4, 32'h0000_5555, 1'b0);
    release_req(3); wait_rsp();
    cur = "hi0_hi";
    issue(3, 1'b0, 16'h0002, 1'b0); push(3, 1, 32'h0000_AAAA, 1'b0);
    release_req(3); wait_rsp();

    // upper address bits: flagged or aliased depending on build
    cur = "range";
    issue(2, 1'b1, 16'h0200, 1'b0);
`ifdef MCOC_BOOT_FETCH_RANGE_CHK_EN
    push(2, 1, 32'h0, 1'b1);
`else
    push(2, 3, 32'hAAAA_5555, 1'b0);
`endif
    release_req(2); wait_rsp();
    step(); chk({cur, "/ferr_pulse"}, 32'(ferr[2]), 32'd0);
    cur = "range_after";
    issue(2, 1'b1, 16'h0010, 1'b0);
`ifdef MCOC_BOOT_FETCH_RANGE_CHK_EN
    push(2, 1, 32'hCAFE_F00D, 1'b0);
`else
    push(2, 3, 32'hCAFE_F00D, 1'b0);
`endif
    release_req(2); wait_rsp();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
